// File: rtl/pe_window_feeder_if.sv
// Pixel-load, weight-write and PE-operand bundle of pe_window_feeder.
// master = producer/PE side, slave = the feeder itself.
interface pe_window_feeder_if #(
    parameter int data_width   = 16,
    parameter int weight_width = 16
);
    logic [data_width-1:0]   pix_in;
    logic                    pix_valid;
    logic                    pix_ready;
    logic                    w_we;
    logic [4:0]              w_addr;
    logic [weight_width-1:0] w_dat;
    logic [data_width-1:0]   picDat;
    logic [weight_width-1:0] weightDat;
    logic                    dat_valid;
    logic                    win_first;
    logic                    win_last;
    logic                    frame_done;

    modport master (
        output pix_in, pix_valid, w_we, w_addr, w_dat,
        input  pix_ready, picDat, weightDat, dat_valid, win_first, win_last, frame_done
    );

    modport slave (
        input  pix_in, pix_valid, w_we, w_addr, w_dat,
        output pix_ready, picDat, weightDat, dat_valid, win_first, win_last, frame_done
    );
endinterface

// File: rtl/pe_window_feeder.sv
// Buffers one frame and replays every valid stride-1 window as a gap-free pixel/weight stream.
// Define FEEDER_PINGPONG_EN for two frame banks so loading overlaps streaming.
module pe_window_feeder #(
    parameter int knl_size     = 5,
    parameter int data_width   = 16,
    parameter int weight_width = 16,
    parameter int img_w        = 28,
    parameter int img_h        = 28
) (
    input  logic               clk,
    input  logic               rst_n,
    pe_window_feeder_if.slave  bus
);
    localparam int NPIX = img_w * img_h;
    localparam int AW   = $clog2(NPIX);
    localparam int NW   = knl_size * knl_size;
    localparam int WIDX = (NW > 1) ? $clog2(NW) : 1;

    localparam logic [AW-1:0] K_MAX    = AW'(knl_size - 1);
    localparam logic [AW-1:0] OX_MAX   = AW'(img_w - knl_size);
    localparam logic [AW-1:0] OY_MAX   = AW'(img_h - knl_size);
    localparam logic [AW-1:0] LAST_PIX = AW'(NPIX - 1);
    localparam logic [AW-1:0] IMG_W    = AW'(img_w);
    localparam logic [AW-1:0] KNL      = AW'(knl_size);

    typedef enum logic [1:0] {LOAD, STREAM, DRAIN} state_t;
    state_t state, state_next;

    logic [AW-1:0]           load_addr, kx, ky, ox, oy, rd_addr;
    logic [WIDX-1:0]         w_idx;
    logic                    pix_ready, pix_accept, last_pix, last_elem;
    logic                    start_stream, issue, w_en;
    logic [weight_width-1:0] weights [0:NW-1];

`ifdef FEEDER_PINGPONG_EN
    logic                    fill_sel, fill_full;
    logic [data_width-1:0]   mem [0:1][0:NPIX-1];
`else
    logic [data_width-1:0]   mem [0:NPIX-1];
`endif

    assign pix_accept = bus.pix_valid && pix_ready;
    assign last_pix   = pix_accept && (load_addr == LAST_PIX);
    assign last_elem  = (state == STREAM) && (kx == K_MAX) && (ky == K_MAX)
                        && (ox == OX_MAX) && (oy == OY_MAX);
    assign rd_addr    = (oy + ky) * IMG_W + ox + kx;
    assign w_idx      = WIDX'(ky * KNL + kx);

    // A full fill bank may only be handed over once the streamer is idle or flushing.
`ifdef FEEDER_PINGPONG_EN
    assign start_stream = (fill_full || last_pix) && (state != STREAM);
`else
    assign start_stream = last_pix;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            LOAD:    if (start_stream) state_next = STREAM;
            STREAM:  if (last_elem)    state_next = DRAIN;
            DRAIN:   state_next = start_stream ? STREAM : LOAD;
            default: state_next = LOAD;
        endcase
    end

    always_comb begin
        issue = (state == STREAM);
        w_en  = bus.w_we && (state != STREAM) && (int'(bus.w_addr) < NW);
`ifdef FEEDER_PINGPONG_EN
        pix_ready = !fill_full;
`else
        pix_ready = (state == LOAD);
`endif
    end

    assign bus.pix_ready = pix_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            load_addr <= '0;
`ifdef FEEDER_PINGPONG_EN
        else if (start_stream)
            load_addr <= '0;
        else if (pix_accept && !last_pix)
            load_addr <= load_addr + 1'b1;
`else
        else if (last_pix)
            load_addr <= '0;
        else if (pix_accept)
            load_addr <= load_addr + 1'b1;
`endif
    end

`ifdef FEEDER_PINGPONG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_sel  <= 1'b0;
            fill_full <= 1'b0;
        end else if (start_stream) begin
            fill_sel  <= !fill_sel;
            fill_full <= 1'b0;
        end else if (last_pix) begin
            fill_full <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (pix_accept) mem[fill_sel][load_addr] <= bus.pix_in;
    end
`else
    always_ff @(posedge clk) begin
        if (pix_accept) mem[load_addr] <= bus.pix_in;
    end
`endif

    // Window walk: kx fastest, then ky, then ox, then oy; all wrap to 0 after the last element.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kx <= '0;
            ky <= '0;
            ox <= '0;
            oy <= '0;
        end else if (issue) begin
            if (kx != K_MAX) begin
                kx <= kx + 1'b1;
            end else begin
                kx <= '0;
                if (ky != K_MAX) begin
                    ky <= ky + 1'b1;
                end else begin
                    ky <= '0;
                    if (ox != OX_MAX) begin
                        ox <= ox + 1'b1;
                    end else begin
                        ox <= '0;
                        oy <= (oy == OY_MAX) ? '0 : oy + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NW; i++) weights[i] <= '0;
        end else if (w_en) begin
            weights[bus.w_addr[WIDX-1:0]] <= bus.w_dat;
        end
    end

    // The RAM read register doubles as the output stage, so data lands one cycle after issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.picDat     <= '0;
            bus.weightDat  <= '0;
            bus.dat_valid  <= 1'b0;
            bus.win_first  <= 1'b0;
            bus.win_last   <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.dat_valid  <= issue;
            bus.win_first  <= issue && (kx == '0) && (ky == '0);
            bus.win_last   <= issue && (kx == K_MAX) && (ky == K_MAX);
            bus.frame_done <= (state == DRAIN);
            if (issue) begin
`ifdef FEEDER_PINGPONG_EN
                bus.picDat <= mem[!fill_sel][rd_addr];
`else
                bus.picDat <= mem[rd_addr];
`endif
                bus.weightDat <= weights[w_idx];
            end else begin
                bus.picDat    <= '0;
                bus.weightDat <= '0;
            end
        end
    end
endmodule

// File: tb/tb_pe_window_feeder.sv
// Directed bench for pe_window_feeder with a 3x3 kernel over a 5x5 frame.
// Pixel value = base + raster index; expected stream comes from a small window-walk model.
module tb_pe_window_feeder;
    localparam int K  = 3;
    localparam int W  = 5;
    localparam int H  = 5;
    localparam int OW = W - K + 1;
    localparam int NV = (W - K + 1) * (H - K + 1) * K * K;

`ifdef FEEDER_PINGPONG_EN
    localparam bit READY_WHILE_STREAMING = 1'b1;
`else
    localparam bit READY_WHILE_STREAMING = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pe_window_feeder_if #(.data_width(16), .weight_width(16)) bus ();

    pe_window_feeder #(
        .knl_size(K), .data_width(16), .weight_width(16), .img_w(W), .img_h(H)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [15:0] wexp [0:8];

    logic [15:0] cap_pix [0:127];
    logic [15:0] cap_w   [0:127];
    logic        cap_f   [0:127];
    logic        cap_l   [0:127];
    int   n_valid, n_first, n_last, first_c, last_c, done_c, zero_bad;
    logic ready_done, ready_first, ready_mid;
    bit   timed_out;

    function automatic int exp_pix(input int base, input int idx);
        int w, e;
        w = idx / (K * K);
        e = idx % (K * K);
        return base + (w / OW + e / K) * W + (w % OW) + (e % K);
    endfunction

    function automatic int data_errors(input int base);
        int errs = 0;
        for (int i = 0; i < NV; i++) begin
            if (cap_pix[i] !== 16'(exp_pix(base, i))) errs++;
            if (cap_w[i]   !== wexp[i % (K * K)])     errs++;
            if (cap_f[i]   !== (i % (K * K) == 0))     errs++;
            if (cap_l[i]   !== (i % (K * K) == K * K - 1)) errs++;
        end
        return errs;
    endfunction

    task automatic write_weight(input int a, input int d);
        @(negedge clk);
        bus.w_we   = 1'b1;
        bus.w_addr = 5'(a);
        bus.w_dat  = 16'(d);
        @(negedge clk);
        bus.w_we   = 1'b0;
    endtask

    task automatic program_weights();
        for (int i = 0; i < K * K; i++) begin
            write_weight(i, i + 1);
            wexp[i] = 16'(i + 1);
        end
    endtask

    task automatic load_frame(input bit gappy, input int base);
        for (int i = 0; i < W * H; i++) begin
            if (gappy) begin
                @(negedge clk);
                bus.pix_valid = 1'b0;
                bus.pix_in    = 16'hBEEF;
            end
            @(negedge clk);
            bus.pix_valid = 1'b1;
            bus.pix_in    = 16'(base + i);
        end
        @(negedge clk);
        bus.pix_valid = 1'b0;
        bus.pix_in    = '0;
    endtask

    // Records one streamed frame; optionally writes weight 0 at cycle wr_cyc or resets at the rst_at-th valid.
    task automatic capture(input int wr_cyc, input int rst_at);
        n_valid = 0; n_first = 0; n_last = 0; zero_bad = 0;
        first_c = -1; last_c = -1; done_c = -1;
        ready_done = 1'bx; ready_first = 1'bx; ready_mid = 1'bx;
        timed_out = 1'b1;
        for (int i = 0; i < 128; i++) begin
            cap_pix[i] = 'x; cap_w[i] = 'x; cap_f[i] = 1'bx; cap_l[i] = 1'bx;
        end
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            bus.w_we = 1'b0;
            if (c == 0)  ready_first = bus.pix_ready;
            if (c == 60) ready_mid   = bus.pix_ready;
            if (bus.dat_valid) begin
                if (n_valid < 128) begin
                    cap_pix[n_valid] = bus.picDat;
                    cap_w[n_valid]   = bus.weightDat;
                    cap_f[n_valid]   = bus.win_first;
                    cap_l[n_valid]   = bus.win_last;
                end
                n_valid++;
                if (first_c < 0) first_c = c;
                last_c = c;
                if (bus.win_first) n_first++;
                if (bus.win_last)  n_last++;
            end else if (bus.picDat !== 16'd0 || bus.weightDat !== 16'd0) begin
                zero_bad++;
            end
            if (bus.frame_done) begin
                done_c     = c;
                ready_done = bus.pix_ready;
                timed_out  = 1'b0;
                break;
            end
            if (c == wr_cyc) begin
                bus.w_we = 1'b1; bus.w_addr = 5'd0; bus.w_dat = 16'd100;
            end
            if (rst_at > 0 && n_valid == rst_at) begin
                rst_n     = 1'b0;
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.pix_valid = 1'b0; bus.pix_in = '0;
        bus.w_we = 1'b0; bus.w_addr = '0; bus.w_dat = '0;
        repeat (3) @(negedge clk);
        checks++; if ({bus.dat_valid, bus.win_first, bus.win_last, bus.frame_done} !== 4'b0) begin failures++; $display("[TB] FAIL reset_flags got=%b exp=0000", {bus.dat_valid, bus.win_first, bus.win_last, bus.frame_done}); end
        checks++; if (bus.picDat !== 16'd0 || bus.weightDat !== 16'd0) begin failures++; $display("[TB] FAIL reset_data got=%0d/%0d exp=0/0", bus.picDat, bus.weightDat); end
        checks++; if (bus.pix_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_pix_ready got=%b exp=1", bus.pix_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_first_frame();
        int first_win  [9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
        int second_win [4] = '{1, 2, 3, 6};
        int errs;
        program_weights();
        write_weight(16, 16'hEEEE);
        write_weight(31, 16'hEEEE);
        load_frame(1'b0, 0);
        capture(-1, 0);
        checks++; if (timed_out) begin failures++; $display("[TB] FAIL frame1_timeout got=no_frame_done exp=frame_done"); end
        for (int e = 0; e < 9; e++) begin
            checks++; if (cap_pix[e] !== 16'(first_win[e])) begin failures++; $display("[TB] FAIL win0_pix[%0d] got=%0d exp=%0d", e, cap_pix[e], first_win[e]); end
            checks++; if (cap_w[e] !== 16'(e + 1)) begin failures++; $display("[TB] FAIL win0_weight[%0d] got=%0d exp=%0d", e, cap_w[e], e + 1); end
        end
        checks++; if (cap_f[0] !== 1'b1 || cap_l[8] !== 1'b1) begin failures++; $display("[TB] FAIL win0_markers got=first:%b last:%b exp=1/1", cap_f[0], cap_l[8]); end
        for (int e = 0; e < 4; e++) begin
            checks++; if (cap_pix[9 + e] !== 16'(second_win[e])) begin failures++; $display("[TB] FAIL win1_pix[%0d] got=%0d exp=%0d", e, cap_pix[9 + e], second_win[e]); end
        end
        checks++; if (first_c !== 0) begin failures++; $display("[TB] FAIL first_latency got=%0d exp=0", first_c); end
        checks++; if (n_valid !== NV) begin failures++; $display("[TB] FAIL valid_count got=%0d exp=%0d", n_valid, NV); end
        checks++; if (last_c - first_c !== NV - 1) begin failures++; $display("[TB] FAIL gapless_span got=%0d exp=%0d", last_c - first_c, NV - 1); end
        checks++; if (n_first !== 9 || n_last !== 9) begin failures++; $display("[TB] FAIL marker_counts got=%0d/%0d exp=9/9", n_first, n_last); end
        checks++; if (cap_pix[NV-1] !== 16'd24 || cap_w[NV-1] !== 16'd9) begin failures++; $display("[TB] FAIL last_elem got=%0d/%0d exp=24/9", cap_pix[NV-1], cap_w[NV-1]); end
        checks++; if (done_c !== last_c + 1) begin failures++; $display("[TB] FAIL frame_done_cycle got=%0d exp=%0d", done_c, last_c + 1); end
        checks++; if (ready_done !== 1'b1) begin failures++; $display("[TB] FAIL ready_after_frame got=%b exp=1", ready_done); end
        checks++; if (ready_first !== READY_WHILE_STREAMING) begin failures++; $display("[TB] FAIL ready_while_streaming got=%b exp=%b", ready_first, READY_WHILE_STREAMING); end
        checks++; if (zero_bad !== 0) begin failures++; $display("[TB] FAIL idle_data_nonzero got=%0d exp=0", zero_bad); end
        errs = data_errors(0);
        checks++; if (errs !== 0) begin failures++; $display("[TB] FAIL frame1_stream got=%0d_errors exp=0", errs); end
        @(negedge clk);
        checks++; if (bus.frame_done !== 1'b0) begin failures++; $display("[TB] FAIL frame_done_width got=%b exp=0", bus.frame_done); end
    endtask

    task automatic test_pix_valid_gaps();
        int errs;
        load_frame(1'b1, 0);
        capture(-1, 0);
        errs = data_errors(0);
        checks++; if (timed_out || n_valid !== NV) begin failures++; $display("[TB] FAIL gappy_count got=%0d exp=%0d", n_valid, NV); end
        checks++; if (errs !== 0) begin failures++; $display("[TB] FAIL gappy_stream got=%0d_errors exp=0", errs); end
    endtask

    task automatic test_weight_write();
        int errs;
        load_frame(1'b0, 50);
        capture(20, 0);
        errs = data_errors(50);
        checks++; if (errs !== 0) begin failures++; $display("[TB] FAIL stream_weight_write_ignored got=%0d_errors exp=0", errs); end
        write_weight(0, 100);
        wexp[0] = 16'd100;
        load_frame(1'b0, 7);
        capture(-1, 0);
        errs = data_errors(7);
        checks++; if (cap_w[0] !== 16'd100) begin failures++; $display("[TB] FAIL load_weight_write got=%0d exp=100", cap_w[0]); end
        checks++; if (errs !== 0) begin failures++; $display("[TB] FAIL new_weight_stream got=%0d_errors exp=0", errs); end
        write_weight(0, 1);
        wexp[0] = 16'd1;
    endtask

    task automatic test_reset_mid_stream();
        int errs;
        load_frame(1'b0, 0);
        capture(-1, 40);
        checks++; if (n_valid !== 40) begin failures++; $display("[TB] FAIL reset_point got=%0d exp=40", n_valid); end
        @(posedge clk);
        #1;
        checks++; if ({bus.dat_valid, bus.win_first, bus.win_last, bus.frame_done} !== 4'b0 || bus.picDat !== 16'd0 || bus.weightDat !== 16'd0) begin failures++; $display("[TB] FAIL midreset_outputs got=%b/%0d/%0d exp=0000/0/0", {bus.dat_valid, bus.win_first, bus.win_last, bus.frame_done}, bus.picDat, bus.weightDat); end
        checks++; if (bus.pix_ready !== 1'b1) begin failures++; $display("[TB] FAIL midreset_pix_ready got=%b exp=1", bus.pix_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < K * K; i++) wexp[i] = 16'd0;
        load_frame(1'b0, 30);
        capture(-1, 0);
        errs = data_errors(30);
        checks++; if (timed_out || n_valid !== NV || first_c !== 0) begin failures++; $display("[TB] FAIL reload_count got=%0d@%0d exp=%0d@0", n_valid, first_c, NV); end
        checks++; if (errs !== 0) begin failures++; $display("[TB] FAIL reload_stream got=%0d_errors exp=0", errs); end
        program_weights();
    endtask

`ifdef FEEDER_PINGPONG_EN
    task automatic test_pingpong();
        int errs;
        load_frame(1'b0, 0);
        fork
            load_frame(1'b0, 200);
            capture(-1, 0);
        join
        errs = data_errors(0);
        checks++; if (errs !== 0 || n_valid !== NV) begin failures++; $display("[TB] FAIL pp_frame_a got=%0d_errors exp=0", errs); end
        checks++; if (ready_mid !== 1'b0) begin failures++; $display("[TB] FAIL pp_ready_both_full got=%b exp=0", ready_mid); end
        capture(-1, 0);
        errs = data_errors(200);
        checks++; if (first_c !== 0) begin failures++; $display("[TB] FAIL pp_frame_b_start got=%0d exp=0", first_c); end
        checks++; if (ready_first !== 1'b1) begin failures++; $display("[TB] FAIL pp_ready_after_swap got=%b exp=1", ready_first); end
        checks++; if (errs !== 0 || n_valid !== NV) begin failures++; $display("[TB] FAIL pp_frame_b got=%0d_errors exp=0", errs); end
    endtask
`endif

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_first_frame();
        test_pix_valid_gaps();
        test_weight_write();
        test_reset_mid_stream();
`ifdef FEEDER_PINGPONG_EN
        test_pingpong();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
